// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port synchronous memory between instruction fetch and load/store data.
// Round-robin on ties, one fixed-latency access at a time, one-cycle ack back to the winner.
module mem_port_arbiter #(
    parameter int unsigned AW      = 10,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ack,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Requester identity used for both the current owner and last_grant.
    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_D  = 1'b1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            owner_q, owner_d;
    logic            win_c;

    logic            mem_en_d, mem_we_d, if_ack_d, d_ack_d, busy_d;
    logic [AW-1:0]   mem_addr_d;
    logic [DW-1:0]   mem_wdata_d, if_rdata_d, d_rdata_d;
    logic [BW-1:0]   mem_be_d;

    // Data side wins when it is the only requester, or on a tie after a fetch grant.
    assign win_c = d_req && (!if_req || (last_q == SRC_IF));

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        owner_d     = owner_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_be_d    = mem_be;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_d  = win_c;
                    last_d   = win_c;
                    mem_en_d = 1'b1;
                    state_d  = ISSUE;
                    if (win_c == SRC_D) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_we ? d_be : {BW{1'b1}};
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = {BW{1'b1}};
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CW'(MEM_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (owner_q == SRC_D) begin
                        d_ack_d = 1'b1;
                        if (!mem_we) d_rdata_d = mem_rdata;
                    end else begin
                        if_ack_d = 1'b1;
                        if (!mem_we) if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= SRC_D;
            owner_q   <= SRC_IF;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_be    <= mem_be_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
            if_ack    <= if_ack_d;
            d_ack     <= d_ack_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=4), each with a latency-exact
// memory, a transaction-level model checked every cycle, and directed scenarios with literal checks.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]               if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, busy;
    logic [1:0][AW-1:0]       if_addr, d_addr, mem_addr;
    logic [1:0][DW-1:0]       if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic [1:0][BW-1:0]       d_be, mem_be;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(g == 0 ? LAT0 : LAT1)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ack(if_ack[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_be(d_be[g]), .d_rdata(d_rdata[g]), .d_ack(d_ack[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_be(mem_be[g]), .mem_rdata(mem_rdata[g]),
            .busy(busy[g])
        );
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? int'(LAT0) : int'(LAT1);
    endfunction

    // ---------------- memory macro model ----------------
    logic [DW-1:0] wmem   [2][1024];
    bit            wvalid [2][1024];
    int            rd_ctr [2];
    logic [AW-1:0] rd_addr[2];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        case (a)
            10'h010: return 32'h0050_0093;
            10'h020: return 32'h1111_1111;
            10'h030: return 32'h1234_5678;
            10'h050: return 32'h0000_0F50;
            10'h060: return 32'h0000_0D60;
            10'h3FF: return 32'hCAFE_F00D;
            default: return 32'h5A00_0000 | 32'(a);
        endcase
    endfunction

    function automatic logic [DW-1:0] rd_word(input int k, input logic [AW-1:0] a);
        return wvalid[k][a] ? wmem[k][a] : init_val(a);
    endfunction

    // Read data is presented only in the exact cycle MEM_LAT after the enable cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) rd_ctr[k] <= 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (mem_en[k]) begin
                    if (mem_we[k]) begin
                        logic [DW-1:0] w;
                        w = rd_word(k, mem_addr[k]);
                        for (int b = 0; b < int'(BW); b++)
                            if (mem_be[k][b]) w[b*8 +: 8] = mem_wdata[k][b*8 +: 8];
                        wmem[k][mem_addr[k]]   <= w;
                        wvalid[k][mem_addr[k]] <= 1'b1;
                        rd_ctr[k] <= 0;
                    end else begin
                        rd_ctr[k] <= lat_of(k);
                    end
                    rd_addr[k] <= mem_addr[k];
                end else if (rd_ctr[k] > 0) begin
                    rd_ctr[k] <= rd_ctr[k] - 1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++)
            mem_rdata[k] = (rd_ctr[k] == 1) ? rd_word(k, rd_addr[k]) : 32'h0BAD_0BAD;
    end

    // ---------------- transaction-level model ----------------
    int            left    [2];
    bit            m_last  [2];
    bit            m_owner [2];
    bit            m_we    [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic [BW-1:0] m_be    [2];
    logic [DW-1:0] e_if_rd [2];
    logic [DW-1:0] e_d_rd  [2];

    // left = cycles of the current access still to come (enable .. ack), 0 when idle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                left[k] = 0; m_last[k] = 1'b1; m_owner[k] = 1'b0; m_we[k] = 1'b0;
                m_addr[k] = '0; m_wdata[k] = '0; m_be[k] = '0;
                e_if_rd[k] = '0; e_d_rd[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (left[k] == 0) begin
                    if (if_req[k] || d_req[k]) begin
                        bit win;
                        if (if_req[k] && d_req[k]) win = ~m_last[k];
                        else                       win = d_req[k];
                        m_owner[k] = win;
                        m_last[k]  = win;
                        if (win) begin
                            m_we[k] = d_we[k]; m_addr[k] = d_addr[k]; m_wdata[k] = d_wdata[k];
                            m_be[k] = d_we[k] ? d_be[k] : 4'hF;
                        end else begin
                            m_we[k] = 1'b0; m_addr[k] = if_addr[k]; m_be[k] = 4'hF;
                        end
                        left[k] = lat_of(k) + 2;
                    end
                end else begin
                    if (left[k] == 2 && !m_we[k]) begin
                        if (m_owner[k]) e_d_rd[k]  = rd_word(k, m_addr[k]);
                        else            e_if_rd[k] = rd_word(k, m_addr[k]);
                    end
                    left[k] = left[k] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("k%0d busy", k),     64'(busy[k]),     64'(left[k] > 0));
            check($sformatf("k%0d mem_en", k),   64'(mem_en[k]),   64'(left[k] == lat_of(k) + 2));
            check($sformatf("k%0d if_ack", k),   64'(if_ack[k]),   64'(left[k] == 1 && !m_owner[k]));
            check($sformatf("k%0d d_ack", k),    64'(d_ack[k]),    64'(left[k] == 1 && m_owner[k]));
            check($sformatf("k%0d if_rdata", k), 64'(if_rdata[k]), 64'(e_if_rd[k]));
            check($sformatf("k%0d d_rdata", k),  64'(d_rdata[k]),  64'(e_d_rd[k]));
            if (left[k] > 0) begin
                check($sformatf("k%0d mem_addr", k), 64'(mem_addr[k]), 64'(m_addr[k]));
                check($sformatf("k%0d mem_we", k),   64'(mem_we[k]),   64'(m_we[k]));
                check($sformatf("k%0d mem_be", k),   64'(mem_be[k]),   64'(m_be[k]));
                if (m_we[k])
                    check($sformatf("k%0d mem_wdata", k), 64'(mem_wdata[k]), 64'(m_wdata[k]));
            end
        end
    end

    // ---------------- directed scenarios ----------------
    int            ack_who[$];
    int            ack_cyc[$];
    int            en_cyc[$];
    logic          en_we[$];
    logic [BW-1:0] en_be[$];
    int            busy_q[$];

    // Observes instance k until n_acks acks (or the cycle budget), dropping reqs when acked.
    task automatic run(input int k, input bit drop_on_ack, input int n_acks, input int max_cyc);
        int seen = 0;
        int c = 0;
        ack_who.delete(); ack_cyc.delete(); en_cyc.delete();
        en_we.delete(); en_be.delete(); busy_q.delete();
        while (seen < n_acks && c < max_cyc) begin
            logic fa, da;
            @(negedge clk);
            fa = if_ack[k];
            da = d_ack[k];
            if (mem_en[k]) begin
                en_cyc.push_back(cyc); en_we.push_back(mem_we[k]); en_be.push_back(mem_be[k]);
            end
            if (busy[k]) busy_q.push_back(cyc);
            if (fa) begin ack_who.push_back(0); ack_cyc.push_back(cyc); seen++; end
            if (da) begin ack_who.push_back(1); ack_cyc.push_back(cyc); seen++; end
            @(posedge clk); #1;
            if (drop_on_ack) begin
                if (fa) if_req[k] = 1'b0;
                if (da) d_req[k]  = 1'b0;
            end
            c++;
        end
        check($sformatf("k%0d acks within budget", k), 64'(seen), 64'(n_acks));
    endtask

    initial begin
        int t0;
        int n_ack;
        int exp_seq[6] = '{0, 1, 0, 1, 0, 1};
        if_req = '0; if_addr = '0; d_req = '0; d_we = '0; d_addr = '0; d_wdata = '0; d_be = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy[0]), 64'd0);
        check("reset mem_addr", 64'(mem_addr[0]), 64'd0);
        check("reset if_rdata", 64'(if_rdata[1]), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // single fetch, MEM_LAT=1
        if_addr[0] = 10'h010; if_req[0] = 1'b1; t0 = cyc;
        run(0, 1'b1, 1, 20);
        check("t1 who", 64'(ack_who[0]), 64'd0);
        check("t1 ack latency", 64'(ack_cyc[0] - t0), 64'd3);
        check("t1 en latency", 64'(en_cyc[0] - t0), 64'd1);
        check("t1 en count", 64'(en_cyc.size()), 64'd1);
        check("t1 if_rdata", 64'(if_rdata[0]), 64'h0050_0093);
        check("t1 d_rdata", 64'(d_rdata[0]), 64'd0);

        // load to give d_rdata a known value, then a byte-masked store
        d_we[0] = 1'b0; d_addr[0] = 10'h030; d_req[0] = 1'b1;
        run(0, 1'b1, 1, 20);
        check("ld d_rdata", 64'(d_rdata[0]), 64'h1234_5678);
        d_we[0] = 1'b1; d_addr[0] = 10'h020; d_wdata[0] = 32'hDEAD_BEEF; d_be[0] = 4'b0011;
        d_req[0] = 1'b1; t0 = cyc;
        run(0, 1'b1, 1, 20);
        check("t4 en count", 64'(en_cyc.size()), 64'd1);
        check("t4 mem_we", 64'(en_we[0]), 64'd1);
        check("t4 mem_be", 64'(en_be[0]), 64'b0011);
        check("t4 who", 64'(ack_who[0]), 64'd1);
        check("t4 ack latency", 64'(ack_cyc[0] - t0), 64'd3);
        check("t4 d_rdata kept", 64'(d_rdata[0]), 64'h1234_5678);
        check("t4 mem word", 64'(rd_word(0, 10'h020)), 64'h1111_BEEF);
        d_we[0] = 1'b0;

        // simultaneous first requests after reset
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        if_addr[0] = 10'h050; d_addr[0] = 10'h060;
        if_req[0] = 1'b1; d_req[0] = 1'b1; t0 = cyc;
        run(0, 1'b1, 2, 40);
        check("t2 first who", 64'(ack_who[0]), 64'd0);
        check("t2 if_ack latency", 64'(ack_cyc[0] - t0), 64'd3);
        check("t2 second who", 64'(ack_who[1]), 64'd1);
        check("t2 d_ack latency", 64'(ack_cyc[1] - t0), 64'd7);
        check("t2 d en cycle", 64'(en_cyc[1] - t0), 64'd5);
        check("t2 if_rdata", 64'(if_rdata[0]), 64'h0000_0F50);
        check("t2 d_rdata", 64'(d_rdata[0]), 64'h0000_0D60);

        // both requesters held for six accesses: strict alternation
        if_req[0] = 1'b1; d_req[0] = 1'b1;
        run(0, 1'b0, 6, 100);
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        for (int i = 0; i < 6; i++)
            check($sformatf("t3 grant %0d", i), 64'(ack_who[i]), 64'(exp_seq[i]));
        for (int i = 0; i < 5; i++)
            check($sformatf("t3 spacing %0d", i), 64'(ack_cyc[i+1] - ack_cyc[i]), 64'd4);
        repeat (3) @(posedge clk); #1;

        // MEM_LAT=4 load from the top word
        d_we[1] = 1'b0; d_addr[1] = 10'h3FF; d_req[1] = 1'b1; t0 = cyc;
        run(1, 1'b1, 1, 40);
        check("t5 ack latency", 64'(ack_cyc[0] - t0), 64'd6);
        check("t5 d_rdata", 64'(d_rdata[1]), 64'hCAFE_F00D);
        check("t5 busy cycles", 64'(busy_q.size()), 64'd6);
        check("t5 busy start", 64'(busy_q[0] - t0), 64'd1);
        check("t5 en latency", 64'(en_cyc[0] - t0), 64'd1);

        // reset asserted mid-WAIT abandons the access
        d_addr[1] = 10'h030; d_req[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6 busy before rst", 64'(busy[1]), 64'd1);
        rst = 1'b0; d_req[1] = 1'b0;
        #1;
        check("t6 busy", 64'(busy[1]), 64'd0);
        check("t6 mem_en", 64'(mem_en[1]), 64'd0);
        check("t6 d_rdata", 64'(d_rdata[1]), 64'd0);
        check("t6 mem_addr", 64'(mem_addr[1]), 64'd0);
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (d_ack[1] || if_ack[1]) n_ack++;
            if (i == 2) begin @(posedge clk); #1 rst = 1'b1; end
        end
        check("t6 no ack", 64'(n_ack), 64'd0);
        @(posedge clk); #1;
        if_addr[1] = 10'h010; if_req[1] = 1'b1; t0 = cyc;
        run(1, 1'b1, 1, 40);
        check("t6 who", 64'(ack_who[0]), 64'd0);
        check("t6 ack latency", 64'(ack_cyc[0] - t0), 64'd6);
        check("t6 if_rdata", 64'(if_rdata[1]), 64'h0050_0093);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
